// File: rtl/poll_accumulator_pkg.sv
// Shared constants and types for the multiply-add chain and its result accumulator.
package Pollparametr;

  localparam int Const         = 8;
  localparam int N_SAMPLES_DEF = 4;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

endpackage

// File: rtl/poll_accumulator.sv
// Sums N_SAMPLES consecutive multiply-add results and offers the total on a valid/ready port.
// Upstream cannot stall: samples arriving while a total is blocked are dropped and flagged.
module poll_accumulator
  import Pollparametr::*;
#(
  parameter int WIDTH     = 2 * Const,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ACC_W     = WIDTH + $clog2(N_SAMPLES)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ACC_W-1:0]             out_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_SAMPLES)-1:0] sample_cnt,
  output logic                         drop_err
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;

  function automatic logic [ACC_W-1:0] widen(input logic [WIDTH-1:0] x);
    return ACC_W'(x);
  endfunction

  // A blocked total can still be replaced in the same cycle it is taken downstream.
  assign in_ready = (state == ACCUM) || ((state == HOLD) && out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ACCUM;
      acc        <= '0;
      sample_cnt <= '0;
      out_sum    <= '0;
      out_valid  <= 1'b0;
      drop_err   <= 1'b0;
    end else if (clr) begin
      state      <= ACCUM;
      acc        <= '0;
      sample_cnt <= '0;
      out_sum    <= '0;
      out_valid  <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (sample_cnt == LAST_IDX) begin
              out_sum    <= acc + widen(in_data);
              out_valid  <= 1'b1;
              state      <= HOLD;
              acc        <= '0;
              sample_cnt <= '0;
            end else begin
              acc        <= acc + widen(in_data);
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
            // N_SAMPLES >= 2, so a lone sample here never closes a group.
            if (in_valid) begin
              acc        <= widen(in_data);
              sample_cnt <= CNT_W'(1);
            end
          end else if (in_valid) begin
            drop_err <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
